// File: rtl/aes_pkg.sv
// Shared AES/Rijndael helpers: byte layout, row offsets, legal block widths.
package aes_pkg;

    localparam int NB_LEGAL[3] = '{4, 6, 8};

    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    function automatic int byte_idx(input int r, input int c);
        return 4 * c + r;
    endfunction

    // Rows 2 and 3 shift one further for 256-bit blocks.
    function automatic int shift_off(input int nb, input int r);
        if (nb == 8 && r >= 2)
            return r + 1;
        return r;
    endfunction

endpackage

// File: rtl/shiftrows_route.sv
// Combinational ShiftRows byte permutation for NB columns.
// SHIFTROWS_PIPE_INV_EN adds the inv_i select for InvShiftRows routing.
module shiftrows_route
    import aes_pkg::*;
#(
    parameter int NB = 4,
    localparam int W = 32 * NB
) (
    input  logic [W-1:0] state_i,
`ifdef SHIFTROWS_PIPE_INV_EN
    input  logic         inv_i,
`endif
    output logic [W-1:0] state_o
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int OFF = shift_off(NB, r);
            localparam int DST = byte_idx(r, c);
            localparam int FWD = byte_idx(r, (c + OFF) % NB);
`ifdef SHIFTROWS_PIPE_INV_EN
            localparam int INV = byte_idx(r, (c - OFF + NB) % NB);
            assign state_o[8*DST +: 8] = inv_i ? state_i[8*INV +: 8]
                                               : state_i[8*FWD +: 8];
`else
            assign state_o[8*DST +: 8] = state_i[8*FWD +: 8];
`endif
        end
    end

endmodule

// File: rtl/shiftrows_pipe.sv
// Pipelined ShiftRows with valid/ready slots and a completed-block counter.
// SHIFTROWS_PIPE_INV_EN enables per-block InvShiftRows via in_inv.
module shiftrows_pipe
    import aes_pkg::*;
#(
    parameter int NB          = 4,
    parameter int PIPE_STAGES = 1,
    parameter int CNT_W       = 16,
    localparam int W = 32 * NB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [W-1:0]     state_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     state_out,
    output logic             done,
    output logic [CNT_W-1:0] blk_count
);

    if (!nb_legal(NB)) begin : g_bad_nb
        $error("shiftrows_pipe: NB must be 4, 6 or 8");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_ps
        $error("shiftrows_pipe: PIPE_STAGES must be 1..4");
    end

    logic [W-1:0]           routed;
    logic [PIPE_STAGES-1:0] v_q, v_d, adv, src_v;
    logic [PIPE_STAGES:0]   ld;
    logic [W-1:0]           d_q   [PIPE_STAGES];
    logic [W-1:0]           d_d   [PIPE_STAGES];
    logic [W-1:0]           src_d [PIPE_STAGES];
    logic                   done_q, done_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

`ifdef SHIFTROWS_PIPE_INV_EN
    shiftrows_route #(.NB(NB)) u_route (
        .state_i (state_in),
        .inv_i   (in_inv),
        .state_o (routed)
    );
`else
    logic unused_inv;
    assign unused_inv = in_inv;

    shiftrows_route #(.NB(NB)) u_route (
        .state_i (state_in),
        .state_o (routed)
    );
`endif

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_src
        if (k == 0) begin : g_head
            assign src_v[k] = in_valid;
            assign src_d[k] = routed;
        end else begin : g_body
            assign src_v[k] = v_q[k-1];
            assign src_d[k] = d_q[k-1];
        end
    end

    // ld[k]: slot k can take a new entry this cycle; ld[PIPE_STAGES] is the sink.
    always_comb begin
        ld  = '0;
        adv = '0;
        ld[PIPE_STAGES] = out_ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            adv[k] = v_q[k] & ld[k+1];
            ld[k]  = ~v_q[k] | adv[k];
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            if (ld[k]) begin
                v_d[k] = src_v[k];
                if (src_v[k])
                    d_d[k] = src_d[k];
            end
        end
    end

    assign done_d = v_q[PIPE_STAGES-1] & out_ready;
    assign cnt_d  = cnt_q + CNT_W'(done_d);

    always_ff @(posedge clk) begin
        if (!rst) begin
            v_q    <= '0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            for (int k = 0; k < PIPE_STAGES; k++)
                d_q[k] <= '0;
        end else begin
            v_q    <= v_d;
            d_q    <= d_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
        end
    end

    assign in_ready  = rst & ld[0];
    assign out_valid = v_q[PIPE_STAGES-1];
    assign state_out = d_q[PIPE_STAGES-1];
    assign done      = done_q;
    assign blk_count = cnt_q;

endmodule

// File: doc/shiftrows_pipe.md
# shiftrows_pipe

Parametrised, pipelined AES/Rijndael ShiftRows unit with valid/ready handshake, replacing the single-register, enable-strobed ShiftRows stage in the round datapath. It supports Rijndael block widths NB = 4, 6 or 8 columns and an optional per-block inverse (InvShiftRows) mode. It sits between SubBytes and MixColumns, or between InvSubBytes and AddRoundKey on the decrypt path. It sustains one block per cycle and holds data under backpressure without loss.

## Interface
- `NB`, default 4: state columns; legal values 4, 6, 8; state width W = 32*NB.
- `PIPE_STAGES`, default 1: register slots between input and output; legal range 1..4.
- `CNT_W`, default 16: width of the completed-block counter.
- `clk` input 1: clock; all logic on its rising edge.
- `rst` input 1: reset; synchronous, active-low.
- `in_valid` input 1: `state_in`/`in_inv` hold a block.
- `in_ready` output 1: block accepted on a cycle with `in_valid && in_ready`.
- `in_inv` input 1: 1 = InvShiftRows, 0 = ShiftRows; sampled with the block.
- `state_in` input W: byte s(r,c) at bits [8*(4c+r)+7 : 8*(4c+r)]; s0,0 in [7:0].
- `out_valid` output 1: `state_out` holds a finished block.
- `out_ready` input 1: downstream accepts on `out_valid && out_ready`.
- `state_out` output W: transformed block, same byte layout.
- `done` output 1: one-cycle pulse, registered, the cycle after each output handshake.
- `blk_count` output CNT_W: number of output handshakes since reset; wraps modulo 2^CNT_W.

## Operation
- Row shift offsets C(r):
  - NB=4 or NB=6: C = {0,1,2,3}.
  - NB=8: C = {0,1,3,4}.
- Forward mode: out s(r,c) = in s(r, (c + C(r)) mod NB).
- Inverse mode: out s(r,c) = in s(r, (c − C(r) + NB) mod NB).
- The transform is pure byte routing and is applied combinationally before the stage-0 register. The mode bit travels with each block, so mixed-mode back-to-back blocks are legal.
- Pipeline: `PIPE_STAGES` slots, each holding data and a valid bit.
  - Slot k advances when slot k+1 is empty or advancing.
  - The last slot advances when `out_ready` is high.
- `in_ready` = slot 0 empty OR slot 0 advancing. It is combinational from `out_ready` through the chain; there is no combinational path from data.
- `out_valid` and `state_out` are driven directly from the last slot.
- Once `out_valid` is high, `state_out` stays stable until the handshake.
- `blk_count` increments on each output handshake and wraps to 0 past its maximum value.
- Reset (rst=0 at an edge):
  - All valid bits and slot data clear to 0.
  - `state_out` = 0, `out_valid` = 0, `done` = 0, `blk_count` = 0.
  - `in_ready` = 0 while rst=0; it returns to 1 in the first cycle after reset is released.
  - Blocks in flight are discarded with no `done` pulse.
- Simultaneous input and output handshakes on a full pipeline: the block shifts through and none is lost or duplicated.
- `in_valid` high with illegal NB: not supported; elaboration fails via a generate-time check on NB and PIPE_STAGES.

## Timing
- Latency: block accepted at edge t appears with `out_valid`=1 after edge t+PIPE_STAGES−1, so it is visible in the cycle following the accepting edge when PIPE_STAGES=1.
- `done` asserts for exactly one cycle after each output handshake edge.
- Throughput is 1 block/cycle with `out_ready` held at 1.
- Under a stall, the pipeline absorbs up to PIPE_STAGES blocks, then `in_ready` falls in the same cycle.

## Configuration
- `SHIFTROWS_PIPE_INV_EN` defined: `in_inv` is honoured and the inverse routing mux is built.
- Macro not defined:
  - `in_inv` is ignored and only forward routing is synthesised.
  - The mode bit is not stored in the pipeline.
  - The port remains present for interface compatibility.

## Structure
- Shared package `aes_pkg`:
  - Byte index function `byte_idx(r,c)`.
  - Row-offset constant function `shift_off(nb, r)`.
  - Legal NB values.
- One sub-module, `shiftrows_route`: combinational byte permutation parameterised by NB, with an inverse input under the macro. It is instantiated once, before slot 0.

## Test plan
- NB=4, forward, FIPS-197 Appendix B:
  - `state_in` bytes 0..15 = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
  - Required output bytes = d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5.
  - `done` pulses once and `blk_count` = 1.
- NB=4, inverse (macro on): feed the above output with `in_inv`=1 → original bytes restored. Also interleave forward/inverse blocks back-to-back with `out_ready`=1 → each block transformed per its own mode, one output per cycle.
- NB=8, forward, byte k = k for k = 0..31 → output s(1,0)=5, s(2,0)=14, s(3,0)=19, s(0,0)=0.
- PIPE_STAGES=2, `out_ready`=0 for 4 cycles while `in_valid`=1:
  - Exactly 2 blocks are accepted, then `in_ready`=0.
  - After `out_ready`=1, blocks exit in order with no loss; `blk_count` = total blocks sent.
- Reset mid-stream: rst=0 with 2 blocks in flight → next cycle `out_valid`=0, `state_out`=0, `blk_count`=0, no `done`; the first post-reset block emerges after the nominal latency.
- CNT_W=4, 17 back-to-back blocks → `blk_count` reads 1 after wrap.
